// File: rtl/axi_width_pkg.sv
// Shared width-conversion helpers for the AXI-stream up/down sizers:
// the clog2 wrapper, byte-occupancy arithmetic and the EMPTY/SEND state
// encoding.
package axi_width_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } width_state_e;

  // clog2 that never returns zero, so derived vector widths stay legal
  function automatic int clog2w(input int value);
    int r;
    r = $clog2(value);
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  // Number of narrow words needed to hold a given number of bytes
  function automatic int bytes_to_words(input int bytes, input int word_bytes);
    return (bytes + word_bytes - 1) / word_bytes;
  endfunction

  // Bytes occupied in the last narrow word (0 means the word is full)
  function automatic int bytes_mod_word(input int bytes, input int word_bytes);
    return bytes % word_bytes;
  endfunction

endpackage

// File: rtl/axi_fifo_downsize_if.sv
// AXI-stream bundle used on both sides of the width converters.
// The tuser width defaults to the byte-occupancy width for the data bus.
interface axi_fifo_downsize_if #(
  parameter int DW = 32,
  parameter int UW = axi_width_pkg::clog2w(DW / 8)
);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axi_fifo_downsize.sv
// axi_fifo_downsize: splits each wide AXI-stream beat of RATIO*OUT_WIDTH bits
// into RATIO narrow words, most-significant word first, carrying the
// packet-tail byte occupancy (tuser) across the width change.
//
// Build option: define AXI_FIFO_DOWNSIZE_TRIM_EN to drop trailing narrow
// words of the last beat that hold no valid bytes. Without it every beat
// emits RATIO words and the tail occupancy is folded into the final word.
module axi_fifo_downsize
  import axi_width_pkg::*;
#(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  axi_fifo_downsize_if.slave    i,
  axi_fifo_downsize_if.master   o
);

  localparam int IN_WIDTH  = OUT_WIDTH * RATIO;
  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  localparam int IN_UW     = clog2w(IN_BYTES);
  localparam int OUT_UW    = clog2w(OUT_BYTES);
  localparam int IDX_W     = clog2w(RATIO);
`ifndef AXI_FIFO_DOWNSIZE_TRIM_EN
  // Bytes carried by all words ahead of the final one in an untrimmed beat
  localparam int PAD_BYTES = (RATIO - 1) * OUT_BYTES;
`endif

  // Holding register and per-beat bookkeeping
  width_state_e          state_r;
  logic [IN_WIDTH-1:0]   hold_r;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      last_idx_r;
  logic                  last_r;
  logic [OUT_UW-1:0]     tail_r;

  // Registered output word
  logic [OUT_WIDTH-1:0]  o_tdata_r;
  logic                  o_tlast_r;
  logic [OUT_UW-1:0]     o_tuser_r;

  // Combinational helpers
  logic                  final_s;
  logic                  i_tready_s;
  logic                  capture_s;
  logic [IN_UW:0]        beat_bytes_s;
  logic [IDX_W-1:0]      cap_last_idx_s;
  logic [OUT_UW-1:0]     cap_tail_s;
  logic [IDX_W-1:0]      idx_nxt_s;
  logic [OUT_WIDTH-1:0]  next_word_s;
  logic                  next_final_s;
  int                    next_sel_s;

  // Handshake: accept a new beat when idle or as the final word leaves
  always_comb begin
    final_s = (state_r == ST_SEND) && (idx_r == last_idx_r);
    if (state_r == ST_EMPTY) begin
      i_tready_s = 1'b1;
    end else begin
      i_tready_s = final_s && o.tready;
    end
    capture_s = i_tready_s && i.tvalid;
  end

  // Occupancy of the incoming beat, evaluated one bit wider so a full beat does not wrap
  always_comb begin
    cap_last_idx_s = IDX_W'(RATIO - 1);
    cap_tail_s     = {OUT_UW{1'b0}};
    if (i.tuser == {IN_UW{1'b0}}) begin
      beat_bytes_s = (IN_UW + 1)'(IN_BYTES);
    end else begin
      beat_bytes_s = {1'b0, i.tuser};
    end
`ifdef AXI_FIFO_DOWNSIZE_TRIM_EN
    if (i.tlast) begin
      cap_last_idx_s = IDX_W'(bytes_to_words(int'(beat_bytes_s), OUT_BYTES) - 1);
      cap_tail_s     = OUT_UW'(bytes_mod_word(int'(beat_bytes_s), OUT_BYTES));
    end else begin
      cap_last_idx_s = IDX_W'(RATIO - 1);
      cap_tail_s     = {OUT_UW{1'b0}};
    end
`else
    if (i.tlast) begin
      if (int'(beat_bytes_s) > PAD_BYTES) begin
        cap_tail_s = OUT_UW'(int'(beat_bytes_s) - PAD_BYTES);
      end else begin
        cap_tail_s = OUT_UW'(1);
      end
    end else begin
      cap_tail_s = {OUT_UW{1'b0}};
    end
`endif
  end

  // Next narrow word of the held beat and whether it closes the beat
  always_comb begin
    idx_nxt_s    = idx_r + IDX_W'(1);
    next_sel_s   = 0;
    next_word_s  = {OUT_WIDTH{1'b0}};
    next_final_s = 1'b0;
    if (idx_r < last_idx_r) begin
      next_sel_s   = RATIO - 2 - int'(idx_r);
      next_word_s  = hold_r[next_sel_s*OUT_WIDTH +: OUT_WIDTH];
      next_final_s = (idx_nxt_s == last_idx_r);
    end else begin
      next_sel_s   = 0;
      next_word_s  = {OUT_WIDTH{1'b0}};
      next_final_s = 1'b0;
    end
  end

  // EMPTY/SEND state machine with registered output word
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r    <= ST_EMPTY;
      hold_r     <= {IN_WIDTH{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      last_idx_r <= {IDX_W{1'b0}};
      last_r     <= 1'b0;
      tail_r     <= {OUT_UW{1'b0}};
      o_tdata_r  <= {OUT_WIDTH{1'b0}};
      o_tlast_r  <= 1'b0;
      o_tuser_r  <= {OUT_UW{1'b0}};
    end else if (capture_s) begin
      state_r    <= ST_SEND;
      hold_r     <= i.tdata;
      idx_r      <= {IDX_W{1'b0}};
      last_idx_r <= cap_last_idx_s;
      last_r     <= i.tlast;
      tail_r     <= cap_tail_s;
      o_tdata_r  <= i.tdata[IN_WIDTH-1 -: OUT_WIDTH];
      if (i.tlast && (cap_last_idx_s == {IDX_W{1'b0}})) begin
        o_tlast_r <= 1'b1;
        o_tuser_r <= cap_tail_s;
      end else begin
        o_tlast_r <= 1'b0;
        o_tuser_r <= {OUT_UW{1'b0}};
      end
    end else begin
      case (state_r)
        ST_SEND: begin
          if (o.tready) begin
            if (final_s) begin
              state_r   <= ST_EMPTY;
              o_tlast_r <= 1'b0;
              o_tuser_r <= {OUT_UW{1'b0}};
            end else begin
              idx_r     <= idx_nxt_s;
              o_tdata_r <= next_word_s;
              if (last_r && next_final_s) begin
                o_tlast_r <= 1'b1;
                o_tuser_r <= tail_r;
              end else begin
                o_tlast_r <= 1'b0;
                o_tuser_r <= {OUT_UW{1'b0}};
              end
            end
          end
        end
        ST_EMPTY: begin
          state_r <= ST_EMPTY;
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  assign i.tready = i_tready_s;
  assign o.tvalid = (state_r == ST_SEND);
  assign o.tdata  = o_tdata_r;
  assign o.tlast  = o_tlast_r;
  assign o.tuser  = o_tuser_r;

endmodule

// File: tb/tb_axi_fifo_downsize.sv
// Scoreboard bench for axi_fifo_downsize: a RATIO=2 and a RATIO=4 instance
// (OUT_WIDTH=32) are driven from a stimulus process; accepted beats are
// expanded by a byte-count reference model into expected narrow words, and
// a monitor compares every output word, stall stability and i_tready.
module tb_axi_fifo_downsize;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst4, clr;

  axi_fifo_downsize_if #(.DW(64),  .UW(3)) i2 ();
  axi_fifo_downsize_if #(.DW(32),  .UW(2)) o2 ();
  axi_fifo_downsize_if #(.DW(128), .UW(4)) i4 ();
  axi_fifo_downsize_if #(.DW(32),  .UW(2)) o4 ();

  axi_fifo_downsize #(.OUT_WIDTH(32), .RATIO(2)) dut2 (
    .clk(clk), .reset(rst2), .clear(clr), .i(i2), .o(o2));
  axi_fifo_downsize #(.OUT_WIDTH(32), .RATIO(4)) dut4 (
    .clk(clk), .reset(rst4), .clear(clr), .i(i4), .o(o4));

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  user;
    logic        beat_end;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_cnt[2];
  int last_out_cyc[2];
  logic stall_v[2];
  logic [34:0] stall_w[2];
  bit bp2 = 1'b0;
  bit bp4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: expand one accepted wide beat into narrow words by byte counting.
  task automatic model_push(input int r, input logic [127:0] d, input int u, input logic l);
    int wb, bytes, n, t;
    exp_t e;
    wb = 4;
    bytes = (u == 0) ? r * wb : u;
    n = r;
`ifdef AXI_FIFO_DOWNSIZE_TRIM_EN
    if (l) n = (bytes + wb - 1) / wb;
    t = bytes % wb;
`else
    t = (bytes > (r - 1) * wb) ? bytes - (r - 1) * wb : 1;
`endif
    for (int k = 0; k < n; k++) begin
      e.data     = d[(r-1-k)*32 +: 32];
      e.beat_end = (k == n - 1);
      e.last     = l && (k == n - 1);
      e.user     = e.last ? t[1:0] : 2'd0;
      if (r == 2) q2.push_back(e);
      else        q4.push_back(e);
    end
  endtask

  task automatic mon(input int s, input logic v, input logic rdy, input logic [31:0] d,
                     input logic l, input logic [1:0] u, input logic itr);
    exp_t e;
    logic [34:0] w;
    bit have;
    w = {d, l, u};
    if (stall_v[s] && v) check(w == stall_w[s], "stall_hold", w, stall_w[s]);
    stall_v[s] = v && !rdy;
    stall_w[s] = w;
    if (!v) begin
      check(itr == 1'b1, "i_tready_idle", itr, 1);
    end else begin
      if (s == 0) begin have = (q2.size() != 0); if (have) e = q2[0]; end
      else        begin have = (q4.size() != 0); if (have) e = q4[0]; end
      check(have, "word_expected", w, 0);
      if (have) begin
        check(itr == (e.beat_end && rdy), "i_tready_send", itr, e.beat_end && rdy);
        if (rdy) begin
          if (s == 0) void'(q2.pop_front());
          else        void'(q4.pop_front());
          check(w == {e.data, e.last, e.user}, "word", w, {e.data, e.last, e.user});
          out_cnt[s]++;
          last_out_cyc[s] = cyc;
        end
      end
    end
  endtask

  // Monitor: check outputs first, then record any input beat accepted this cycle
  always @(negedge clk) begin
    if (!rst2) begin
      mon(0, o2.tvalid, o2.tready, o2.tdata, o2.tlast, o2.tuser, i2.tready);
      if (i2.tvalid && i2.tready) model_push(2, {64'd0, i2.tdata}, int'(i2.tuser), i2.tlast);
    end
    if (!rst4) begin
      mon(1, o4.tvalid, o4.tready, o4.tdata, o4.tlast, o4.tuser, i4.tready);
      if (i4.tvalid && i4.tready) model_push(4, i4.tdata, int'(i4.tuser), i4.tlast);
    end
  end

  // Output backpressure
  initial begin
    o2.tready = 1'b1;
    o4.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o2.tready = bp2 ? 1'($urandom_range(0, 1)) : 1'b1;
      o4.tready = bp4 ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drv(input int s, input logic [127:0] d, input logic [3:0] u, input logic l, output int hs);
    int n;
    n = 0;
    if (s == 0) begin
      i2.tdata = d[63:0]; i2.tuser = u[2:0]; i2.tlast = l; i2.tvalid = 1'b1;
    end else begin
      i4.tdata = d; i4.tuser = u; i4.tlast = l; i4.tvalid = 1'b1;
    end
    @(negedge clk);
    while (!(s == 0 ? i2.tready : i4.tready) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check((s == 0 ? i2.tready : i4.tready) == 1'b1, "input_accept_timeout", n, 1000);
    hs = cyc;
    @(posedge clk); #1;
    if (s == 0) i2.tvalid = 1'b0;
    else        i4.tvalid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q2.size() != 0 || q4.size() != 0) && n < limit) begin
      n++;
      @(posedge clk); #1;
    end
    check(q2.size() == 0, "drain_q2", q2.size(), 0);
    check(q4.size() == 0, "drain_q4", q4.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hs, c0, oc0, nb;
    logic [63:0] d;
    rst2 = 1'b1; rst4 = 1'b1; clr = 1'b0;
    i2.tvalid = 1'b0; i2.tdata = '0; i2.tuser = '0; i2.tlast = 1'b0;
    i4.tvalid = 1'b0; i4.tdata = '0; i4.tuser = '0; i4.tlast = 1'b0;
    out_cnt[0] = 0; out_cnt[1] = 0; last_out_cyc[0] = 0; last_out_cyc[1] = 0;
    stall_v[0] = 1'b0; stall_v[1] = 1'b0; stall_w[0] = '0; stall_w[1] = '0;
    repeat (3) @(posedge clk);
    #1; rst2 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check(o2.tvalid == 1'b0, "rst_o2_tvalid", o2.tvalid, 0);
    check(o2.tlast == 1'b0,  "rst_o2_tlast", o2.tlast, 0);
    check(o2.tuser == 2'd0,  "rst_o2_tuser", o2.tuser, 0);
    check(i2.tready == 1'b1, "rst_i2_tready", i2.tready, 1);
    check(o4.tvalid == 1'b0, "rst_o4_tvalid", o4.tvalid, 0);
    check(i4.tready == 1'b1, "rst_i4_tready", i4.tready, 1);
    @(posedge clk); #1;

    // Directed packets: 4 beats with tail 7, then tail 4
    for (int k = 0; k < 4; k++) begin
      d = 64'hA0000000_A0000001 + 64'(k) * 64'h00000002_00000002;
      drv(0, {64'd0, d}, 4'd7, k == 3, hs);
    end
    for (int k = 0; k < 4; k++) begin
      d = 64'hA0000000_A0000001 + 64'(k) * 64'h00000002_00000002;
      drv(0, {64'd0, d}, 4'd4, k == 3, hs);
    end
    drv(1, 128'h00010203_04050607_08090A0B_0C0D0E0F, 4'd9, 1'b1, hs);
    drain(100);

    // Randomized packets under 50% backpressure on both instances
    bp2 = 1'b1; bp4 = 1'b1;
    fork
      begin
        int h;
        for (int p = 0; p < 16; p++) begin
          int m;
          m = $urandom_range(1, 4);
          for (int b = 0; b < m; b++)
            drv(0, {64'd0, $urandom, $urandom}, 4'($urandom_range(0, 7)), b == m - 1, h);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      begin
        int h;
        for (int p = 0; p < 16; p++) begin
          int m;
          m = $urandom_range(1, 3);
          for (int b = 0; b < m; b++)
            drv(1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), b == m - 1, h);
        end
      end
    join
    drain(2000);
    bp2 = 1'b0; bp4 = 1'b0;
    @(posedge clk); #1;

    // Reset after the first of two words of a beat has left
    drv(0, {64'd0, 64'hC0000000_C0000001}, 4'd0, 1'b1, hs);
    @(posedge clk); #1;
    rst2 = 1'b1;
    q2.delete();
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    check(o2.tvalid == 1'b0, "post_reset_tvalid", o2.tvalid, 0);
    @(posedge clk); #1;
    drv(0, {64'd0, 64'hB0000000_B0000001}, 4'd0, 1'b1, hs);
    @(negedge clk);
    check(o2.tvalid && o2.tdata == 32'hB0000000, "post_reset_first", o2.tdata, 32'hB0000000);
    drain(100);
    @(posedge clk); #1;

    // Throughput: 100 back-to-back beats with o_tready held high
    oc0 = out_cnt[0];
    c0 = 0;
    nb = 0;
    for (int k = 0; k < 100; k++) begin
      drv(0, {64'd0, $urandom, $urandom}, 4'd0, (k % 10) == 9, hs);
      if (k == 0) c0 = hs;
      nb++;
    end
    drain(100);
    check(out_cnt[0] - oc0 == 2 * nb, "tp_word_count", out_cnt[0] - oc0, 2 * nb);
    check(last_out_cyc[0] == c0 + 200, "tp_last_cycle", last_out_cyc[0], c0 + 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_fifo_downsize.md
Name: axi_fifo_downsize

Overview:
- Parametrised successor to the fixed 64→32 AXI-stream packer.
- Splits each wide input beat of RATIO*OUT_WIDTH bits into RATIO narrow output words, most-significant word first.
- Carries the packet-tail byte-occupancy (tuser) through the width change. Optionally trims unused narrow words on the final beat.
- Sits between wide datapath FIFOs and narrow links (e.g. 128/64-bit CHDR to 32-bit host/ethernet framers).

Parameters:
- OUT_WIDTH, 32, narrow word width in bits; multiple of 8.
- RATIO, 2, narrow words per input beat; integer ≥2 (not restricted to powers of 2).
- IN_WIDTH, OUT_WIDTH*RATIO, derived; not overridable.
- IN_UW, clog2(IN_WIDTH/8), derived input tuser width.
- OUT_UW, clog2(OUT_WIDTH/8), derived output tuser width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset
- i_tdata  in  IN_WIDTH  wide data
- i_tuser  in  IN_UW  valid bytes in the last beat (0 = all bytes); ignored when i_tlast=0
- i_tlast  in  1  end of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  OUT_WIDTH  narrow data
- o_tuser  out  OUT_UW  valid bytes in the last word (0 = all bytes); 0 on non-last words
- o_tlast  out  1  end of packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Behaviour:
- Clocking and reset: one clock domain. Reset and clear are synchronous and active-high (port `reset`); they are identical in effect.
  - On reset/clear: holding register empty, word index 0, o_tvalid=0, o_tlast=0, o_tuser=0, i_tready=1.
  - Reset mid-packet drops the partially sent beat. The next input beat is treated as a fresh beat.
- Storage: one holding register for the wide beat, plus word index idx (0..RATIO-1), nwords (1..RATIO), last flag and tail occupancy.
- States:
  - EMPTY: o_tvalid=0, i_tready=1. On i_tvalid, capture the beat and go to SEND with idx=0.
  - SEND: o_tvalid=1, o_tdata = word[RATIO-1-idx], where word[k] = bits k*OUT_WIDTH+:OUT_WIDTH.
    - On o_tready: idx++.
    - On the final word (idx==nwords-1) with o_tready: if i_tvalid, capture the next beat (idx=0, stay in SEND); otherwise go to EMPTY.
- i_tready = EMPTY | (SEND & final word & o_tready). This gives full throughput: a new beat is accepted in the same cycle the last word leaves.
- Latency: first narrow word is valid one cycle after the input handshake.
- Each input beat takes nwords cycles when o_tready is held high.
- nwords:
  - Non-last beat: RATIO.
  - Last beat with TRIM: ceil(B/(OUT_WIDTH/8)), where B = i_tuser, or IN_WIDTH/8 when i_tuser=0.
- o_tlast=1 only on the final word of a last beat. On that word, o_tuser = B mod (OUT_WIDTH/8); a result of 0 means a full word.
- Occupancy arithmetic is computed at capture time in IN_UW+1 bits, so B=IN_WIDTH/8 does not wrap.
- o_tdata, o_tlast and o_tuser hold stable while o_tvalid & ~o_tready (AXI rule). A word is never dropped or duplicated.
- Single-beat packets (tlast on the first beat) and back-to-back packets need no idle cycle between them.

Optional Feature:
- Macro: AXI_FIFO_DOWNSIZE_TRIM_EN.
- When defined: last-beat trimming as above. Narrow words that hold no valid bytes are not emitted.
- When undefined:
  - nwords is always RATIO, and the last beat emits all RATIO words.
  - o_tlast is on word RATIO-1.
  - o_tuser on that word = B - (RATIO-1)*(OUT_WIDTH/8) when B exceeds that amount, else 1. Downstream must tolerate padding words. This mode saves the divider/LUT.

Decomposition:
- Shared package axi_width_pkg: byte-occupancy helper function (bytes→words, bytes mod word), the clog2 wrapper, and the state enum for EMPTY/SEND. The package is reused by the planned axi_fifo_upsize.
- No sub-module. Occupancy calculation is an inline function from the package.

Test Plan:
- OUT_WIDTH=32, RATIO=2, TRIM. Send 4 beats starting 64'hA0000000_A0000001, +64'h0000_0002_0000_0002 per beat, tuser=7, o_tready=1.
  - Expected: A0000000, A0000001, …, A0000006, A0000007.
  - Last word: tlast=1, tuser=3. Total 8 words in 8 consecutive cycles.
- Same packet with tuser=4 on the last beat: 7 words; final word A0000006 with tlast=1, tuser=0. Repeat with the macro undefined: 8 words; A0000007 with tlast=1, tuser=1.
- RATIO=4, OUT_WIDTH=32. Single-beat packet 128'h00010203_04050607_08090A0B_0C0D0E0F, tuser=9: 3 words 00010203, 04050607, 08090A0B; tlast on the third word, tuser=1.
- Backpressure: toggle o_tready with a random 50% pattern over 16 back-to-back packets.
  - Output sequence matches the reference model with no loss or duplication.
  - o_tdata is stable while stalled.
  - i_tready never asserts while idx < nwords-1.
- Assert reset for 1 cycle after 1 of 2 words of a beat has been sent: o_tvalid=0 next cycle. A new packet 64'hB0000000_B0000001 then outputs B0000000 first.
- Throughput: continuous i_tvalid with o_tready=1 for 100 beats (RATIO=2) gives exactly 200 output words in 200 cycles after the 1-cycle latency.
